multiplier_datapath: RTL and testbench
======================================

# multiplier_datapath

Register-and-adder datapath for the 8-bit signed add-shift multiplier. It sits directly downstream of the multiplier control unit and consumes that unit's Shift, LoadA, fselect and ClearA strobes. It holds the X:A:B product registers and performs the 9-bit add/subtract of A and the switch operand S. It returns B[0] as M to the control unit each cycle.

## Interface
- WIDTH, 8, operand width. The X:A:B chain is 2*WIDTH+1 bits.
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- S  in  WIDTH  multiplicand (switches), signed two's complement.
- LoadB  in  1  load S into B (multiplier).
- ClearA  in  1  clear X and A (from control unit).
- LoadA  in  1  write adder result into X:A (from control unit).
- Shift  in  1  arithmetic right shift of X:A:B (from control unit).
- fselect  in  1  0 = add S, 1 = subtract S (from control unit).
- M  out  1  B[0], registered-state output to control unit.
- X  out  1  sign-extension bit register.
- Aval  out  WIDTH  A register (product high byte).
- Bval  out  WIDTH  B register (product low byte).
- ShiftErr  out  1  shift-overrun flag (see Configuration).

## Operation
- Reset (Reset=0 at posedge): X=0, A=0, B=0, ShiftErr=0; M=0. Reset overrides every other input, including mid-multiply.
- Adder is combinational and 9 bits wide: R = {A[7],A} + ({S[7],S} XOR {9{fselect}}) + fselect. LoadA writes X <= R[8] and A <= R[7:0]. Carry out of bit 8 is discarded.
- Shift: X <= X, A <= {X, A[7:1]}, B <= {A[0], B[7:1]}.
- LoadB: B <= S. It is independent of the A/X actions, so ClearA and LoadB in the same cycle clear X:A and load B.
- Per-cycle priority for X:A: ClearA > LoadA > Shift > hold.
  - ClearA and Shift in the same cycle: X:A is cleared, and B shifts in a 0 (the cleared A[0]).
  - LoadA and Shift in the same cycle: the load wins. B still holds.
  - For B: LoadB > Shift > hold.
- M = B[0] of the current register state, never combinational from inputs.
- Product after a full sequence is {Aval,Bval}, signed 16-bit.

## Timing
- All register updates take effect one posedge after the strobe is sampled. There is no internal pipelining.
- M reflects a Shift on the cycle after the Shift edge. This is what the control unit's next add state samples.
- A full multiply takes 17 cycles after Run: Clear, then 8 add/shift pairs. The last pair uses fselect=1.
- No handshake. Strobes are level-sampled each cycle, and holding a strobe high repeats its action every cycle.

## Configuration
- Macro: MULT_DP_SHIFT_GUARD_EN.
- Defined:
  - A 4-bit counter clears on Reset or ClearA and increments on each Shift that is accepted.
  - A Shift arriving when the count is already 8 sets ShiftErr. ShiftErr is sticky until Reset or ClearA.
  - The overrun shift is still performed.
- Undefined: no counter; ShiftErr is tied to 0.

## Test plan
- Reset=0 for 1 cycle mid-sequence with A=0x5A, B=0x33, X=1 -> next cycle X=0, A=0x00, B=0x00, M=0.
- Single-op add: A=0x7F, S=0x01, fselect=0, LoadA -> X=0, A=0x80.
- Single-op subtract: A=0x00, S=0x05, fselect=1, LoadA -> X=1, A=0xFB.
- Shift: X=1, A=0xFB, B=0x01, Shift -> A=0xFD, B=0x80, M=0.
- Full multiply under the control-unit strobe sequence, with S loaded as the multiplicand and B as the multiplier; each case ends in the stated {A,B}:
  - S=0x03, B=0x07 -> 0x0015.
  - S=0x03, B=0xFE -> 0xFFFA.
  - S=0x80, B=0x80 -> 0x4000.
- Guard, macro defined: ClearA, then 9 Shift pulses -> ShiftErr=0 after the 8th shift and 1 after the 9th. ClearA then drops it to 0. With the macro undefined, ShiftErr stays 0 throughout.

Source files
------------

// File: rtl/multiplier_datapath_if.sv
// rtl/multiplier_datapath_if.sv - strobe and register-view bundle between multiplier control unit and datapath
interface multiplier_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] S;
    logic             LoadB;
    logic             ClearA;
    logic             LoadA;
    logic             Shift;
    logic             fselect;
    logic             M;
    logic             X;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             ShiftErr;

    modport master (
        output S, LoadB, ClearA, LoadA, Shift, fselect,
        input  M, X, Aval, Bval, ShiftErr
    );

    modport slave (
        input  S, LoadB, ClearA, LoadA, Shift, fselect,
        output M, X, Aval, Bval, ShiftErr
    );
endinterface

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - X:A:B registers and 9-bit add/sub for the signed add-shift multiplier (option MULT_DP_SHIFT_GUARD_EN)
module multiplier_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    multiplier_datapath_if.slave  dp
);

    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   opnd;
    logic [WIDTH:0]   sum;
    logic             b_shift;
    logic             shift_acc;

    // Sign-extended 9-bit add so that -128 +/- S keeps its sign in X.
    always_comb begin
        opnd = {dp.S[WIDTH-1], dp.S} ^ {(WIDTH+1){dp.fselect}};
        sum  = {a_q[WIDTH-1], a_q} + opnd + {{WIDTH{1'b0}}, dp.fselect};
    end

    assign b_shift   = dp.Shift & (dp.ClearA | ~dp.LoadA);
    assign shift_acc = dp.Shift & ~dp.ClearA & ~dp.LoadA;

    always_comb begin
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        if (dp.ClearA) begin
            x_d = 1'b0;
            a_d = '0;
        end else if (dp.LoadA) begin
            x_d = sum[WIDTH];
            a_d = sum[WIDTH-1:0];
        end else if (dp.Shift) begin
            a_d = {x_q, a_q[WIDTH-1:1]};
        end
        // A cleared in the same cycle feeds a 0 into B, not the stale A[0].
        if (dp.LoadB) begin
            b_d = dp.S;
        end else if (b_shift) begin
            b_d = {(dp.ClearA ? 1'b0 : a_q[0]), b_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

`ifdef MULT_DP_SHIFT_GUARD_EN
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Count saturates so a long overrun cannot wrap back into range.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (dp.ClearA) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (shift_acc) begin
            if (cnt_q >= 4'd8) begin
                err_d = 1'b1;
            end
            if (cnt_q != 4'hF) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign dp.ShiftErr = err_q;
`else
    logic unused_shift_acc;
    assign unused_shift_acc = shift_acc;
    assign dp.ShiftErr      = 1'b0;
`endif

    assign dp.M    = b_q[0];
    assign dp.X    = x_q;
    assign dp.Aval = a_q;
    assign dp.Bval = b_q;

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - directed self-checking bench for multiplier_datapath
module tb_multiplier_datapath;

    logic Clk;
    logic Reset;
    int   errors;
    int   checks;

    multiplier_datapath_if #(.WIDTH(8)) dp ();

    multiplier_datapath #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .dp    (dp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        dp.LoadB   = 1'b0;
        dp.ClearA  = 1'b0;
        dp.LoadA   = 1'b0;
        dp.Shift   = 1'b0;
        dp.fselect = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe_loada(input logic [7:0] s, input logic fs);
        idle();
        dp.S = s; dp.fselect = fs; dp.LoadA = 1'b1;
        tick();
        idle();
    endtask

    task automatic multiply(input logic [7:0] mcand, input logic [7:0] mplier,
                            input logic [15:0] exp, input string tag);
        idle();
        dp.S = mplier; dp.LoadB = 1'b1;
        tick();
        idle();
        dp.S = mcand; dp.ClearA = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_m%0d", tag, i), {15'd0, dp.M}, {15'd0, mplier[i]});
            if (mplier[i]) begin
                dp.LoadA = 1'b1; dp.fselect = (i == 7);
                tick();
                idle();
            end else begin
                tick();
            end
            dp.Shift = 1'b1;
            tick();
            idle();
        end
        chk(tag, {dp.Aval, dp.Bval}, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        dp.S   = 8'h00;
        idle();
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        chk("rst_x", {15'd0, dp.X}, 16'h0000);
        chk("rst_a", {8'd0, dp.Aval}, 16'h0000);
        chk("rst_b", {8'd0, dp.Bval}, 16'h0000);
        chk("rst_m", {15'd0, dp.M}, 16'h0000);
        chk("rst_err", {15'd0, dp.ShiftErr}, 16'h0000);

        // Build X=1, A=0x5A, B=0x33 then reset with LoadA also asserted
        dp.S = 8'h33; dp.LoadB = 1'b1; dp.ClearA = 1'b1;
        tick();
        strobe_loada(8'h80, 1'b0);
        strobe_loada(8'hDA, 1'b0);
        chk("pre_rst", {7'd0, dp.X, dp.Aval}, 16'h015A);
        chk("pre_rst_b", {8'd0, dp.Bval}, 16'h0033);
        dp.LoadA = 1'b1; dp.S = 8'h11; Reset = 1'b0;
        tick();
        Reset = 1'b1;
        idle();
        chk("mid_rst_xa", {7'd0, dp.X, dp.Aval}, 16'h0000);
        chk("mid_rst_b", {8'd0, dp.Bval}, 16'h0000);
        chk("mid_rst_m", {15'd0, dp.M}, 16'h0000);

        // Add overflow into sign: 0x7F + 1
        strobe_loada(8'h7F, 1'b0);
        strobe_loada(8'h01, 1'b0);
        chk("add", {7'd0, dp.X, dp.Aval}, 16'h0080);

        // Subtract from zero
        dp.ClearA = 1'b1; dp.S = 8'h01; dp.LoadB = 1'b1;
        tick();
        idle();
        strobe_loada(8'h05, 1'b1);
        chk("sub", {7'd0, dp.X, dp.Aval}, 16'h01FB);

        dp.Shift = 1'b1;
        tick();
        idle();
        chk("shift_a", {7'd0, dp.X, dp.Aval}, 16'h01FD);
        chk("shift_b", {8'd0, dp.Bval}, 16'h0080);
        chk("shift_m", {15'd0, dp.M}, 16'h0000);

        // ClearA + Shift: B takes a 0, not the old A[0]=1
        dp.ClearA = 1'b1; dp.Shift = 1'b1;
        tick();
        idle();
        chk("clr_shift_xa", {7'd0, dp.X, dp.Aval}, 16'h0000);
        chk("clr_shift_b", {8'd0, dp.Bval}, 16'h0040);

        // LoadA + Shift: load wins, B holds
        dp.LoadA = 1'b1; dp.Shift = 1'b1; dp.S = 8'h03;
        tick();
        idle();
        chk("ld_shift_xa", {7'd0, dp.X, dp.Aval}, 16'h0003);
        chk("ld_shift_b", {8'd0, dp.Bval}, 16'h0040);

        // LoadB + Shift: B loads, X:A shifts
        dp.LoadB = 1'b1; dp.Shift = 1'b1; dp.S = 8'hC5;
        tick();
        idle();
        chk("lb_shift_b", {8'd0, dp.Bval}, 16'h00C5);
        chk("lb_shift_a", {7'd0, dp.X, dp.Aval}, 16'h0001);
        chk("lb_shift_m", {15'd0, dp.M}, 16'h0001);

        multiply(8'h03, 8'h07, 16'h0015, "mul_3x7");
        multiply(8'h03, 8'hFE, 16'hFFFA, "mul_3xm2");
        multiply(8'h80, 8'h80, 16'h4000, "mul_m128sq");
        multiply(8'hFB, 8'h06, 16'hFFE2, "mul_m5x6");

        // Shift overrun guard
        dp.ClearA = 1'b1;
        tick();
        idle();
        dp.Shift = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("guard_8", {15'd0, dp.ShiftErr}, 16'h0000);
        tick();
`ifdef MULT_DP_SHIFT_GUARD_EN
        chk("guard_9", {15'd0, dp.ShiftErr}, 16'h0001);
        tick();
        chk("guard_sticky", {15'd0, dp.ShiftErr}, 16'h0001);
`else
        chk("guard_9", {15'd0, dp.ShiftErr}, 16'h0000);
        tick();
        chk("guard_sticky", {15'd0, dp.ShiftErr}, 16'h0000);
`endif
        idle();
        dp.ClearA = 1'b1;
        tick();
        idle();
        chk("guard_clr", {15'd0, dp.ShiftErr}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
